obc_bitslice_feeder: RTL and testbench

Bit-serial front/back end for the OBC DFT ROM stages. Accepts one block of 16 parallel samples and sends them LSB-first as 16-bit bit-slices, one slice per cycle, asserting the sign-slice flag m on the MSB slice. Samples the combinational ROM partial sum returned in the same cycle and shift-accumulates it into the final DFT coefficient. One instance drives one ROM stage (real or imaginary).

---
 rtl/obc_bitslice_feeder_pkg.sv | 16 +
 rtl/obc_bitslice_feeder_if.sv | 32 +++
 rtl/obc_bitslice_feeder_shifter.sv | 46 ++++
 rtl/obc_bitslice_feeder.sv | 108 ++++++++++
 tb/tb_obc_bitslice_feeder.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/obc_bitslice_feeder_pkg.sv
// Shared types and constants for the OBC bit-slice feeder.
// Optional feature macro used by the top: OBC_OFFSET_EN.
package obc_pkg;

    localparam int N_POINTS       = 16;
    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_ROM_W  = 32;
    localparam int DEFAULT_ACC_W  = 48;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/obc_bitslice_feeder_if.sv
// Block/slice/result handshake bundle between the feeder and its neighbours.
import obc_pkg::*;

interface obc_bitslice_feeder_if #(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ROM_W  = DEFAULT_ROM_W,
    parameter int ACC_W  = DEFAULT_ACC_W
);
    logic                         in_valid;
    logic                         in_ready;
    logic [N_POINTS*DATA_W-1:0]   in_data;
    logic [N_POINTS-1:0]          xslice;
    logic                         m;
    logic                         slice_valid;
    logic [ROM_W-1:0]             rom_in;
    logic                         out_valid;
    logic                         out_ready;
    logic [ACC_W-1:0]             out_data;
    logic                         busy;

    // Feeder side
    modport slave (
        input  in_valid, in_data, rom_in, out_ready,
        output in_ready, xslice, m, slice_valid, out_valid, out_data, busy
    );

    // Sample source / ROM / result sink side
    modport master (
        output in_valid, in_data, rom_in, out_ready,
        input  in_ready, xslice, m, slice_valid, out_valid, out_data, busy
    );
endinterface

// File: rtl/obc_bitslice_feeder_shifter.sv
// 16 parallel right-shift registers presenting one bit of every sample per
// cycle, plus the slice counter and the last-slice flag.
import obc_pkg::*;

module obc_slice_shifter #(
    parameter int DATA_W = DEFAULT_DATA_W,
    localparam int IDX_W = $clog2(DATA_W)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                load_i,
    input  logic                                shift_i,
    input  logic [N_POINTS-1:0][DATA_W-1:0]     data_i,
    output logic [N_POINTS-1:0]                 xslice_o,
    output logic [IDX_W-1:0]                    idx_o,
    output logic                                last_o
);
    logic [N_POINTS-1:0][DATA_W-1:0] sr_q;
    logic [IDX_W-1:0]                idx_q;

    // Capture a block, or shift every sample right by one slice
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q  <= '0;
            idx_q <= '0;
        end else if (load_i) begin
            sr_q  <= data_i;
            idx_q <= '0;
        end else if (shift_i) begin
            for (int k = 0; k < N_POINTS; k++)
                sr_q[k] <= sr_q[k] >> 1;
            idx_q <= idx_q + 1'b1;
        end
    end

    // Current slice is the LSB column of the register bank
    always_comb begin
        xslice_o = '0;
        for (int k = 0; k < N_POINTS; k++)
            xslice_o[k] = sr_q[k][0];
    end

    assign idx_o  = idx_q;
    assign last_o = (idx_q == IDX_W'(DATA_W - 1));

endmodule

// File: rtl/obc_bitslice_feeder.sv
// OBC bit-serial feeder: sends a 16-sample block LSB-first as bit-slices to a
// ROM stage and shift-accumulates the returned partial sums into one result.
// Optional macro OBC_OFFSET_EN: preload the accumulator with OFFSET.
import obc_pkg::*;

module obc_bitslice_feeder #(
    parameter int                       DATA_W = DEFAULT_DATA_W,
    parameter int                       ROM_W  = DEFAULT_ROM_W,
    parameter int                       ACC_W  = DEFAULT_ACC_W,
    parameter logic signed [ACC_W-1:0]  OFFSET = '0,
    localparam int                      IDX_W  = $clog2(DATA_W)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    obc_bitslice_feeder_if.slave bus
);
`ifdef OBC_OFFSET_EN
    // Constant term of the OBC expansion folded in at block start
    localparam logic [ACC_W-1:0] ACC_INIT = OFFSET;
`else
    // OFFSET has no effect in this build
    localparam logic [ACC_W-1:0] ACC_INIT = OFFSET & {ACC_W{1'b0}};
`endif

    state_t                          state_q;
    logic [ACC_W-1:0]                acc_q, acc_d;
    logic                            in_ready_q, out_valid_q, busy_q;
    logic [N_POINTS-1:0][DATA_W-1:0] samples;
    logic [N_POINTS-1:0]             xslice_raw;
    logic [IDX_W-1:0]                idx;
    logic                            last;
    logic                            load, shift;
    logic [ACC_W-1:0]                rom_ext;

    assign samples = bus.in_data;
    assign load    = (state_q == IDLE) && bus.in_valid;
    assign shift   = (state_q == SHIFT);

    obc_slice_shifter #(.DATA_W(DATA_W)) u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load),
        .shift_i  (shift),
        .data_i   (samples),
        .xslice_o (xslice_raw),
        .idx_o    (idx),
        .last_o   (last)
    );

    // Weight this slice's partial sum by 2^idx; sign of the MSB slice is the ROM's job
    always_comb begin
        rom_ext = {{(ACC_W-ROM_W){bus.rom_in[ROM_W-1]}}, bus.rom_in};
        acc_d   = acc_q + (rom_ext << idx);
    end

    // Control FSM with registered handshake outputs and the accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        state_q    <= SHIFT;
                        acc_q      <= ACC_INIT;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                SHIFT: begin
                    acc_q <= acc_d;
                    if (last) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // Slice outputs are only driven while shifting so the ROM sees zero otherwise
    assign bus.slice_valid = shift;
    assign bus.xslice      = shift ? xslice_raw : '0;
    assign bus.m           = shift && last;
    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = acc_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_obc_bitslice_feeder.sv
// Directed + randomized bench for obc_bitslice_feeder with a ROM stub and a
// closed-form model of the expected coefficient.
import obc_pkg::*;

module tb_obc_bitslice_feeder;

`ifdef OBC_OFFSET_EN
    localparam longint BASE = -8;
`else
    localparam longint BASE = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    obc_bitslice_feeder_if #(.DATA_W(16), .ROM_W(32), .ACC_W(48)) bus ();

    obc_bitslice_feeder #(.DATA_W(16), .ROM_W(32), .ACC_W(48), .OFFSET(-48'sd8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_chk = 0;
    int          n_pass = 0;
    int          rom_mode = 0;      // 0: popcount, 1: constant -1, 2: signed weighted sum
    int          w [16];
    logic [15:0] blk [16];

    // ROM stage stub
    always_comb begin
        int wsum;
        wsum = 0;
        for (int k = 0; k < 16; k++)
            if (bus.xslice[k]) wsum += w[k];
        case (rom_mode)
            0:       bus.rom_in = 32'($countones(bus.xslice));
            1:       bus.rom_in = 32'hFFFF_FFFF;
            default: bus.rom_in = bus.m ? 32'(-wsum) : 32'(wsum);
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Expected coefficient from the block, computed directly from the math
    function automatic logic [47:0] model(input int mode);
        longint s;
        s = 0;
        for (int k = 0; k < 16; k++) begin
            case (mode)
                0:       s += longint'(blk[k]);
                2:       s += longint'(w[k]) * longint'($signed(blk[k]));
                default: ;
            endcase
        end
        if (mode == 1) s = -65535;
        return 48'(s + BASE);
    endfunction

    function automatic logic [15:0] col(input int j);
        logic [15:0] c;
        for (int k = 0; k < 16; k++) c[k] = blk[k][j];
        return c;
    endfunction

    task automatic drive_block();
        for (int k = 0; k < 16; k++) bus.in_data[k*16 +: 16] = blk[k];
        bus.in_valid = 1'b1;
    endtask

    // One full block: capture, 16 slices, result, optional stall, accept
    task automatic run_block(input string tag, input int mode, input int stall, input bit hold_ready);
        logic [47:0] exp;
        exp = model(mode);
        rom_mode = mode;
        bus.out_ready = hold_ready;
        chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
        drive_block();
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int j = 0; j < 16; j++) begin
            chk($sformatf("%s.slv%0d", tag, j), 64'(bus.slice_valid), 64'd1);
            chk($sformatf("%s.m%0d", tag, j), 64'(bus.m), 64'(j == 15));
            chk($sformatf("%s.xs%0d", tag, j), 64'(bus.xslice), 64'(col(j)));
            if (j == 0 || j == 15) begin
                chk($sformatf("%s.ov%0d", tag, j), 64'(bus.out_valid), 64'd0);
                chk($sformatf("%s.busy%0d", tag, j), 64'(bus.busy), 64'd1);
            end
            @(negedge clk);
        end
        chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, ".out_data"}, 64'(bus.out_data), 64'(exp));
        chk({tag, ".slv_done"}, 64'(bus.slice_valid), 64'd0);
        if (!hold_ready) begin
            for (int c = 0; c < stall; c++) begin
                bus.in_valid = 1'b1;     // offered block must be ignored in DONE
                blk[0] = 16'hDEAD;
                drive_block();
                @(negedge clk);
                chk($sformatf("%s.st_ov%0d", tag, c), 64'(bus.out_valid), 64'd1);
                chk($sformatf("%s.st_od%0d", tag, c), 64'(bus.out_data), 64'(exp));
                chk($sformatf("%s.st_ir%0d", tag, c), 64'(bus.in_ready), 64'd0);
            end
            bus.in_valid = 1'b0;
            bus.out_ready = 1'b1;
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, ".ov_drop"}, 64'(bus.out_valid), 64'd0);
        chk({tag, ".ir_back"}, 64'(bus.in_ready), 64'd1);
        chk({tag, ".busy_off"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_data = '0;
        for (int k = 0; k < 16; k++) w[k] = int'($urandom_range(200)) - 100;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.slice_valid", 64'(bus.slice_valid), 64'd0);
        chk("rst.m", 64'(bus.m), 64'd0);
        chk("rst.xslice", 64'(bus.xslice), 64'd0);
        chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst.out_data", 64'(bus.out_data), 64'd0);
        chk("rst.busy", 64'(bus.busy), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.in_ready", 64'(bus.in_ready), 64'd1);

        // 1: all zero samples
        for (int k = 0; k < 16; k++) blk[k] = 16'h0000;
        run_block("zero", 0, 0, 1'b0);

        // 2: sample k = k
        for (int k = 0; k < 16; k++) blk[k] = 16'(k);
        chk("ramp.first_col", 64'(col(0)), 64'h0000_AAAA);
        run_block("ramp", 0, 1, 1'b0);

        // 3: all ones, popcount then constant -1 ROM
        for (int k = 0; k < 16; k++) blk[k] = 16'hFFFF;
        run_block("ones", 0, 0, 1'b1);
        run_block("neg1", 1, 0, 1'b0);

        // 4: long stall in DONE with a competing block offered
        for (int k = 0; k < 16; k++) blk[k] = 16'($urandom);
        run_block("stall", 2, 10, 1'b0);
        @(negedge clk);
        chk("stall.not_consumed", 64'(bus.busy), 64'd0);

        // 5: reset pulse in the middle of a block
        for (int k = 0; k < 16; k++) blk[k] = 16'hFFFF;
        rom_mode = 0;
        drive_block();
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort.pre_idx7", 64'(bus.xslice), 64'(col(7)));
        #2 rst_n = 1'b0;
        #1;
        chk("abort.slice_valid", 64'(bus.slice_valid), 64'd0);
        chk("abort.m", 64'(bus.m), 64'd0);
        chk("abort.xslice", 64'(bus.xslice), 64'd0);
        chk("abort.out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort.out_data", 64'(bus.out_data), 64'd0);
        chk("abort.busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort.in_ready", 64'(bus.in_ready), 64'd1);
        for (int k = 0; k < 16; k++) blk[k] = 16'h0001;
        run_block("after_abort", 0, 0, 1'b0);

        // Randomized blocks over all ROM stub modes
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < 16; k++) blk[k] = 16'($urandom);
            run_block($sformatf("rnd%0d", b), int'($urandom_range(2)),
                      int'($urandom_range(3)), 1'($urandom_range(1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
